neuron_step_scheduler: RTL and testbench

Time-multiplexes one shared Izhikevich state_update datapath across NUM_NEURONS neurons. Holds per-neuron v, u and accumulated input current. Each step_start sweeps neurons 0..N-1 through the datapath, writes results back and emits one spike event per firing neuron. Injection of synaptic current is accepted between steps.

---
 rtl/izh_pkg.sv | 31 +++
 rtl/neuron_step_scheduler_if.sv | 26 ++
 rtl/neuron_state_mem.sv | 54 +++++
 rtl/neuron_step_scheduler.sv | 147 ++++++++++++++
 tb/tb_neuron_step_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/izh_pkg.sv
// Shared fixed-point types, reset constants, saturating add and scheduler
// state encoding for the Izhikevich neuron step scheduler.
package izh_pkg;

  localparam int DW     = 17;
  localparam int FRAC_W = 8;

  typedef logic signed [DW-1:0] fix_t;

  localparam fix_t V_INIT_DEF = fix_t'(-16640);
  localparam fix_t U_INIT_DEF = fix_t'(-3328);
  localparam fix_t FIX_MAX    = {1'b0, {(DW-1){1'b1}}};
  localparam fix_t FIX_MIN    = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_DONE
  } sched_state_e;

  // One guard bit is enough to detect two's complement overflow of a + b.
  function automatic fix_t sat_add(input fix_t a, input fix_t b);
    logic [DW:0] s;
    s = {a[DW-1], a} + {b[DW-1], b};
    if (s[DW] != s[DW-1]) return s[DW] ? FIX_MIN : FIX_MAX;
    return fix_t'(s[DW-1:0]);
  endfunction

endpackage

// File: rtl/neuron_step_scheduler_if.sv
// Datapath bus between the scheduler (master) and the shared Izhikevich
// state_update datapath (slave).
interface neuron_step_scheduler_if;
  import izh_pkg::*;

  // dp_valid is a one-cycle issue strobe with operands held until dp_done;
  // dp_done is a one-cycle result strobe with no back-pressure either way.
  logic dp_valid;
  fix_t dp_v_in;
  fix_t dp_u_in;
  fix_t dp_i_in;
  logic dp_done;
  fix_t dp_v_out;
  fix_t dp_u_out;
  logic dp_fired;

  modport master (
    output dp_valid, dp_v_in, dp_u_in, dp_i_in,
    input  dp_done, dp_v_out, dp_u_out, dp_fired
  );

  modport slave (
    input  dp_valid, dp_v_in, dp_u_in, dp_i_in,
    output dp_done, dp_v_out, dp_u_out, dp_fired
  );
endinterface

// File: rtl/neuron_state_mem.sv
// Per-neuron v/u/accumulated-current registers with a write-back port and a
// saturating injection port; reset loads the resting state.
module neuron_state_mem
  import izh_pkg::*;
#(
  parameter int   NUM_NEURONS = 4,
  parameter int   IDX_W       = 2,
  parameter fix_t V_INIT      = V_INIT_DEF,
  parameter fix_t U_INIT      = U_INIT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx_i,
  output fix_t             rd_v_o,
  output fix_t             rd_u_o,
  output fix_t             rd_i_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  fix_t             wr_v_i,
  input  fix_t             wr_u_i,
  input  logic             inj_en_i,
  input  logic [IDX_W-1:0] inj_idx_i,
  input  fix_t             inj_cur_i
);

  fix_t v_q [NUM_NEURONS];
  fix_t u_q [NUM_NEURONS];
  fix_t i_q [NUM_NEURONS];

  assign rd_v_o = v_q[rd_idx_i];
  assign rd_u_o = u_q[rd_idx_i];
  assign rd_i_o = i_q[rd_idx_i];

  // Write-back and injection are never active together: injection is IDLE-only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        v_q[n] <= V_INIT;
        u_q[n] <= U_INIT;
        i_q[n] <= '0;
      end
    end else begin
      if (wr_en_i) begin
        v_q[wr_idx_i] <= wr_v_i;
        u_q[wr_idx_i] <= wr_u_i;
        i_q[wr_idx_i] <= '0;
      end
      if (inj_en_i) begin
        i_q[inj_idx_i] <= sat_add(i_q[inj_idx_i], inj_cur_i);
      end
    end
  end

endmodule

// File: rtl/neuron_step_scheduler.sv
// Sweeps all neurons through one shared Izhikevich datapath per step_start.
// Optional NEURON_SCHED_SPIKE_COUNT_EN adds a per-step spike_count output.
module neuron_step_scheduler
  import izh_pkg::*;
#(
  parameter int   NUM_NEURONS = 4,
  parameter int   IDX_W       = 2,
  parameter fix_t V_INIT      = V_INIT_DEF,
  parameter fix_t U_INIT      = U_INIT_DEF
) (
  input  logic                     clk,
  input  logic                     asyn_reset,
  input  logic                     step_start,
  output logic                     busy,
  output logic                     step_done,
  input  logic                     inj_valid,
  output logic                     inj_ready,
  input  logic [IDX_W-1:0]         inj_idx,
  input  fix_t                     inj_current,
  neuron_step_scheduler_if.master  dp,
  output logic                     spike_valid,
  output logic [IDX_W-1:0]         spike_idx,
`ifdef NEURON_SCHED_SPIKE_COUNT_EN
  output logic [IDX_W:0]           spike_count,
`endif
  output sched_state_e             state_dbg
);

  sched_state_e     state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  fix_t             res_v_q, res_v_d;
  fix_t             res_u_q, res_u_d;
  logic             fired_q, fired_d;

  fix_t rd_v, rd_u, rd_i;
  logic step_accept, inj_en, dp_active, wr_en;

  assign step_accept = (state_q == S_IDLE) && step_start;
  assign inj_ready   = (state_q == S_IDLE);
  assign inj_en      = inj_valid && inj_ready && (int'(inj_idx) < NUM_NEURONS);
  assign wr_en       = (state_q == S_WRITE);
  assign dp_active   = (state_q == S_ISSUE) || (state_q == S_WAIT);

  neuron_state_mem #(
    .NUM_NEURONS (NUM_NEURONS),
    .IDX_W       (IDX_W),
    .V_INIT      (V_INIT),
    .U_INIT      (U_INIT)
  ) u_mem (
    .clk       (clk),
    .rst_n     (asyn_reset),
    .rd_idx_i  (idx_q),
    .rd_v_o    (rd_v),
    .rd_u_o    (rd_u),
    .rd_i_o    (rd_i),
    .wr_en_i   (wr_en),
    .wr_idx_i  (idx_q),
    .wr_v_i    (res_v_q),
    .wr_u_i    (res_u_q),
    .inj_en_i  (inj_en),
    .inj_idx_i (inj_idx),
    .inj_cur_i (inj_current)
  );

  always_ff @(posedge clk or negedge asyn_reset) begin
    if (!asyn_reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      res_v_q <= '0;
      res_u_q <= '0;
      fired_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      res_v_q <= res_v_d;
      res_u_q <= res_u_d;
      fired_q <= fired_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    res_v_d = res_v_q;
    res_u_d = res_u_q;
    fired_d = fired_q;
    unique case (state_q)
      S_IDLE: begin
        if (step_start) begin
          state_d = S_ISSUE;
          idx_d   = '0;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (dp.dp_done) begin
          res_v_d = dp.dp_v_out;
          res_u_d = dp.dp_u_out;
          fired_d = dp.dp_fired;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (idx_q == IDX_W'(NUM_NEURONS - 1)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operands are zero outside an issue so idle bus activity stays quiet.
  assign dp.dp_valid = (state_q == S_ISSUE);
  assign dp.dp_v_in  = dp_active ? rd_v : '0;
  assign dp.dp_u_in  = dp_active ? rd_u : '0;
  assign dp.dp_i_in  = dp_active ? rd_i : '0;

  assign busy        = (state_q != S_IDLE);
  assign step_done   = (state_q == S_DONE);
  assign spike_valid = wr_en && fired_q;
  assign spike_idx   = spike_valid ? idx_q : '0;
  assign state_dbg   = state_q;

`ifdef NEURON_SCHED_SPIKE_COUNT_EN
  logic [IDX_W:0] spk_cnt_q;

  always_ff @(posedge clk or negedge asyn_reset) begin
    if (!asyn_reset) begin
      spk_cnt_q <= '0;
    end else if (step_accept) begin
      spk_cnt_q <= '0;
    end else if (spike_valid) begin
      spk_cnt_q <= spk_cnt_q + 1'b1;
    end
  end

  assign spike_count = spk_cnt_q;
`else
  logic unused_accept;
  assign unused_accept = step_accept;
`endif

endmodule

// File: tb/tb_neuron_step_scheduler.sv
// Bench for neuron_step_scheduler: datapath model with configurable latency,
// scoreboarded issue operands and spikes, table-driven injection cases.
module tb_neuron_step_scheduler;
  import izh_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic asyn_reset = 1'b0;
  always #5 clk = ~clk;

  logic           step_start = 1'b0;
  logic           busy, step_done;
  logic           inj_valid = 1'b0;
  logic           inj_ready;
  logic [IW-1:0]  inj_idx = '0;
  fix_t           inj_current = '0;
  logic           spike_valid;
  logic [IW-1:0]  spike_idx;
  sched_state_e   state_dbg;
`ifdef NEURON_SCHED_SPIKE_COUNT_EN
  logic [IW:0]    spike_count;
`endif

  neuron_step_scheduler_if dp_if ();

  neuron_step_scheduler #(.NUM_NEURONS(N), .IDX_W(IW)) dut (
    .clk         (clk),
    .asyn_reset  (asyn_reset),
    .step_start  (step_start),
    .busy        (busy),
    .step_done   (step_done),
    .inj_valid   (inj_valid),
    .inj_ready   (inj_ready),
    .inj_idx     (inj_idx),
    .inj_current (inj_current),
    .dp          (dp_if.master),
    .spike_valid (spike_valid),
    .spike_idx   (spike_idx),
`ifdef NEURON_SCHED_SPIKE_COUNT_EN
    .spike_count (spike_count),
`endif
    .state_dbg   (state_dbg)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- datapath model: v+1, u+2, latency lat ----------------
  int             lat = 1;
  logic [N-1:0]   fire_mask = '0;
  int             m_cnt = 0;
  int             m_idx = 0;
  bit             m_pend = 0;
  fix_t           m_v, m_u;
  logic           m_f;

  always @(negedge clk) begin
    if (!asyn_reset) begin
      m_pend = 0;
      m_idx  = 0;
      dp_if.dp_done  = 1'b0;
      dp_if.dp_fired = 1'b0;
      dp_if.dp_v_out = '0;
      dp_if.dp_u_out = '0;
    end else begin
      dp_if.dp_done = 1'b0;
      if (dp_if.dp_valid) begin
        m_pend = 1;
        m_cnt  = lat;
        m_v    = dp_if.dp_v_in + fix_t'(1);
        m_u    = dp_if.dp_u_in + fix_t'(2);
        m_f    = fire_mask[m_idx];
        m_idx  = (m_idx + 1) % N;
      end else if (m_pend) begin
        m_cnt--;
        if (m_cnt == 0) begin
          dp_if.dp_done  = 1'b1;
          dp_if.dp_v_out = m_v;
          dp_if.dp_u_out = m_u;
          dp_if.dp_fired = m_f;
          m_pend = 0;
        end
      end
    end
  end

  // ---------------- reference state and scoreboard ----------------
  fix_t ref_v [N];
  fix_t ref_u [N];
  fix_t ref_i [N];
  logic [3*DW-1:0] exp_q[$];
  logic [IW-1:0]   spk_q[$];

  function automatic fix_t ref_sat(input fix_t a, input fix_t b);
    int s;
    s = int'(a) + int'(b);
    if (s > 65535) s = 65535;
    if (s < -65536) s = -65536;
    return fix_t'(s);
  endfunction

  task automatic ref_reset();
    for (int n = 0; n < N; n++) begin
      ref_v[n] = fix_t'(-16640);
      ref_u[n] = fix_t'(-3328);
      ref_i[n] = '0;
    end
  endtask

  always @(negedge clk) begin
    if (asyn_reset) begin
      if (dp_if.dp_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL dp_issue_unexpected: got issue expected none at %0t", $time);
        end else begin
          logic [3*DW-1:0] e;
          fix_t ev, eu, ei;
          e = exp_q.pop_front();
          {ev, eu, ei} = e;
          check("dp_v_in", dp_if.dp_v_in, ev);
          check("dp_u_in", dp_if.dp_u_in, eu);
          check("dp_i_in", dp_if.dp_i_in, ei);
        end
      end
      if (spike_valid) begin
        if (spk_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spike_unexpected: got idx %0d expected none at %0t", spike_idx, $time);
        end else begin
          logic [IW-1:0] es;
          es = spk_q.pop_front();
          check("spike_idx", spike_idx, es);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic inject_pair(input logic [IW-1:0] idx, input fix_t a, input fix_t b);
    @(negedge clk);
    check("inj_ready_idle", inj_ready, 1);
    inj_valid = 1'b1; inj_idx = idx; inj_current = a;
    @(negedge clk);
    inj_current = b;
    @(negedge clk);
    inj_valid = 1'b0;
  endtask

  task automatic run_step(input int l, input logic [N-1:0] mask, input bit disturb,
                          input bit sc_inj, input logic [IW-1:0] sc_idx, input fix_t sc_val);
    int cyc;
    bit done_seen;
    lat = l;
    fire_mask = mask;
    @(negedge clk);
    step_start = 1'b1;
    if (sc_inj) begin
      inj_valid = 1'b1; inj_idx = sc_idx; inj_current = sc_val;
      ref_i[sc_idx] = ref_sat(ref_i[sc_idx], sc_val);
    end
    for (int n = 0; n < N; n++) begin
      exp_q.push_back({ref_v[n], ref_u[n], ref_i[n]});
      if (mask[n]) spk_q.push_back(IW'(n));
    end
    @(posedge clk);
    #1;
    step_start = 1'b0;
    inj_valid  = 1'b0;
    check("busy_after_accept", busy, 1);
    cyc = 0;
    done_seen = 0;
    while (!done_seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (disturb && cyc == 3) begin
        check("inj_ready_busy", inj_ready, 0);
        step_start = 1'b1; inj_valid = 1'b1; inj_idx = '0; inj_current = fix_t'(100);
      end else begin
        step_start = 1'b0; inj_valid = 1'b0;
      end
      if (step_done) done_seen = 1;
    end
    check("step_done_latency", cyc, N * (l + 2) + 1);
`ifdef NEURON_SCHED_SPIKE_COUNT_EN
    check("spike_count", spike_count, $countones(mask));
`endif
    @(negedge clk);
    check("busy_after_done", busy, 0);
    check("step_done_pulse", step_done, 0);
    check("state_idle", state_dbg, S_IDLE);
    check("issue_q_empty", exp_q.size(), 0);
    check("spike_q_empty", spk_q.size(), 0);
    for (int n = 0; n < N; n++) begin
      ref_v[n] = ref_v[n] + fix_t'(1);
      ref_u[n] = ref_u[n] + fix_t'(2);
      ref_i[n] = '0;
    end
  endtask

  task automatic reset_mid_sweep();
    int seen;
    int guard;
    bit done_flag;
    lat = 3;
    fire_mask = '0;
    @(negedge clk);
    step_start = 1'b1;
    for (int n = 0; n < N; n++) exp_q.push_back({ref_v[n], ref_u[n], ref_i[n]});
    @(posedge clk);
    #1;
    step_start = 1'b0;
    seen = 0;
    guard = 0;
    while (seen < 3 && guard < 100) begin
      @(negedge clk);
      guard++;
      if (dp_if.dp_valid) seen++;
    end
    check("idx2_issue_seen", seen, 3);
    @(negedge clk);
    check("state_wait_idx2", state_dbg, S_WAIT);
    asyn_reset = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_step_done", step_done, 0);
    check("rst_dp_valid", dp_if.dp_valid, 0);
    check("rst_dp_v_in", dp_if.dp_v_in, 0);
    check("rst_state", state_dbg, S_IDLE);
    exp_q.delete();
    spk_q.delete();
    ref_reset();
    repeat (2) @(negedge clk);
    asyn_reset = 1'b1;
    done_flag = 0;
    repeat (6) begin
      @(negedge clk);
      if (step_done || busy) done_flag = 1;
    end
    check("no_done_after_reset", done_flag, 0);
  endtask

  // ---------------- table of injection vectors ----------------
  typedef struct {
    logic [IW-1:0] idx;
    fix_t          a;
    fix_t          b;
    fix_t          exp_i;
  } inj_vec_t;

  inj_vec_t tbl [4];

  initial begin
    tbl[0] = '{idx: 2'd2, a: fix_t'(17'h00600), b: fix_t'(17'h00600), exp_i: fix_t'(17'h00C00)};
    tbl[1] = '{idx: 2'd1, a: fix_t'(65000),     b: fix_t'(1000),      exp_i: fix_t'(65535)};
    tbl[2] = '{idx: 2'd1, a: fix_t'(-65536),    b: fix_t'(-1),        exp_i: fix_t'(-65536)};
    tbl[3] = '{idx: 2'd0, a: fix_t'(300),       b: fix_t'(-500),      exp_i: fix_t'(-200)};

    ref_reset();
    asyn_reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_step_done", step_done, 0);
    check("reset_dp_valid", dp_if.dp_valid, 0);
    check("reset_dp_v_in", dp_if.dp_v_in, 0);
    check("reset_dp_u_in", dp_if.dp_u_in, 0);
    check("reset_spike_valid", spike_valid, 0);
    check("reset_spike_idx", spike_idx, 0);
    check("reset_inj_ready", inj_ready, 1);
    check("reset_state", state_dbg, S_IDLE);
    asyn_reset = 1'b1;

    run_step(1, 4'b0000, 0, 0, '0, '0);
    run_step(2, 4'b0000, 0, 0, '0, '0);

    for (int k = 0; k < 4; k++) begin
      inject_pair(tbl[k].idx, tbl[k].a, tbl[k].b);
      ref_i[tbl[k].idx] = tbl[k].exp_i;
      run_step(1, 4'b0000, 0, 0, '0, '0);
    end

    run_step(1, 4'b1010, 0, 0, '0, '0);
    run_step(2, 4'b0000, 1, 0, '0, '0);
    run_step(1, 4'b0000, 0, 1, 2'd3, fix_t'(77));

    reset_mid_sweep();
    run_step(1, 4'b0000, 0, 0, '0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
